// File: rtl/mux_scan_sel.sv
// N-channel registered selector: MANUAL picks the channel from sel, SCAN rotates
// through the channels enabled in ch_mask with a programmable dwell per channel.
module mux_scan_sel #(
   parameter int CH    = 4,
   parameter int W     = 1,
   parameter int DWELL = 50,
   parameter int SELW  = $clog2(CH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [CH*W-1:0]   din,
   input  logic [SELW-1:0]   sel,
   input  logic              mode,
   input  logic              en,
   input  logic [CH-1:0]     ch_mask,
   output logic [W-1:0]      dout,
   output logic [SELW-1:0]   cur_ch,
   output logic              ch_strobe
);

   localparam int CW = $clog2(DWELL) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

   typedef enum logic {
      ST_MANUAL = 1'b0,
      ST_SCAN   = 1'b1
   } state_t;

   state_t          state_q, state_d;
   state_t          mode_st;
   logic [CW-1:0]   cnt_q, cnt_d, cnt_eff;
   logic [SELW-1:0] cur_ch_q, cur_ch_d;
   logic [W-1:0]    dout_q, dout_d;
   logic            strobe_q, strobe_d;
   logic [SELW-1:0] scan_nxt;
   logic [SELW-1:0] nxt;
   int              srch_dist;
   int              srch_best;

   assign mode_st = mode ? ST_SCAN : ST_MANUAL;

   // Nearest enabled channel after cur_ch (wrapping); cur_ch itself ranks last,
   // so an empty mask or a mask holding only cur_ch leaves the channel unchanged.
   always_comb begin
      srch_best = CH + 1;
      srch_dist = 0;
      scan_nxt  = cur_ch_q;
      for (int k = 0; k < CH; k++) begin
         srch_dist = k - int'(cur_ch_q);
         if (srch_dist <= 0) begin
            srch_dist = srch_dist + CH;
         end
         if (ch_mask[k] && (srch_dist < srch_best)) begin
            srch_best = srch_dist;
            scan_nxt  = SELW'(k);
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      cur_ch_d = cur_ch_q;
      dout_d   = dout_q;
      strobe_d = 1'b0;
      nxt      = cur_ch_q;
      // A mode change restarts the dwell from zero on this very edge.
      cnt_eff  = (mode_st == state_q) ? cnt_q : '0;
      if (en) begin
         state_d = mode_st;
         if (mode_st == ST_MANUAL) begin
            cnt_d = '0;
            if (int'(sel) < CH) begin
               nxt = sel;
            end
         end else if (cnt_eff == CNT_LAST) begin
            cnt_d = '0;
            nxt   = scan_nxt;
         end else begin
            cnt_d = cnt_eff + CW'(1);
         end
         cur_ch_d = nxt;
         strobe_d = (nxt != cur_ch_q);
         for (int k = 0; k < CH; k++) begin
            if (nxt == SELW'(k)) begin
               dout_d = din[k*W +: W];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_MANUAL;
         cnt_q    <= '0;
         cur_ch_q <= '0;
         dout_q   <= '0;
         strobe_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         cur_ch_q <= cur_ch_d;
         dout_q   <= dout_d;
         strobe_q <= strobe_d;
      end
   end

   assign dout      = dout_q;
   assign cur_ch    = cur_ch_q;
   assign ch_strobe = strobe_q;

endmodule

// File: tb/tb_mux_scan_sel.sv
// Bench for mux_scan_sel: per-cycle comparison against a behavioural model plus
// directed literal checks (CH=4, W=1, DWELL=4; a CH=3 instance for sel range).
module tb_mux_scan_sel;

   localparam int CH = 4;
   localparam int DW = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       mode = 1'b0;
   logic       en = 1'b1;
   logic [3:0] din = 4'b0101;
   logic [3:0] ch_mask = 4'hF;
   logic [1:0] sel = 2'd0;
   logic [0:0] dout;
   logic [1:0] cur_ch;
   logic       ch_strobe;

   logic [2:0] din3 = 3'b101;
   logic [1:0] sel3 = 2'd0;
   logic       mode3 = 1'b0;
   logic       en3 = 1'b1;
   logic [2:0] mask3 = 3'b111;
   logic [0:0] dout3;
   logic [1:0] cur3;
   logic       strb3;

   int n_checks = 0;
   int n_fail = 0;

   mux_scan_sel #(.CH(4), .W(1), .DWELL(4)) u_dut (
      .clk(clk), .rst(rst), .din(din), .sel(sel), .mode(mode), .en(en),
      .ch_mask(ch_mask), .dout(dout), .cur_ch(cur_ch), .ch_strobe(ch_strobe)
   );

   mux_scan_sel #(.CH(3), .W(1), .DWELL(4)) u_dut3 (
      .clk(clk), .rst(rst), .din(din3), .sel(sel3), .mode(mode3), .en(en3),
      .ch_mask(mask3), .dout(dout3), .cur_ch(cur3), .ch_strobe(strb3)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // Behavioural model of the selector
   int   m_cur = 0;
   int   m_cnt = 0;
   logic m_scan = 1'b0;
   logic m_dout = 1'b0;
   logic m_strb = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_cur = 0; m_cnt = 0; m_scan = 1'b0; m_dout = 1'b0; m_strb = 1'b0;
      end else if (!en) begin
         m_strb = 1'b0;
      end else begin
         int nxt;
         int c;
         c   = (mode == m_scan) ? m_cnt : 0;
         nxt = m_cur;
         if (!mode) begin
            if (int'(sel) < CH) nxt = int'(sel);
            m_cnt = 0;
         end else if (c == DW - 1) begin
            m_cnt = 0;
            for (int i = 1; i <= CH; i++) begin
               if (ch_mask[(m_cur + i) % CH]) begin
                  nxt = (m_cur + i) % CH;
                  break;
               end
            end
         end else begin
            m_cnt = c + 1;
         end
         m_strb = (nxt != m_cur);
         m_cur  = nxt;
         m_dout = din[nxt];
         m_scan = mode;
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         check("cmp_dout", 32'(dout), 32'(m_dout));
         check("cmp_cur_ch", 32'(cur_ch), 32'(m_cur));
         check("cmp_strobe", 32'(ch_strobe), 32'(m_strb));
      end
   end

   int   sels[4]  = '{0, 2, 1, 3};
   logic exp_d[4] = '{1'b1, 1'b1, 1'b0, 1'b0};

   initial begin
      // Reset state
      tick();
      check("rst_dout", 32'(dout), 0);
      check("rst_cur_ch", 32'(cur_ch), 0);
      check("rst_strobe", 32'(ch_strobe), 0);
      tick();
      rst = 1'b0;

      // MANUAL: sel 0,2,1,3 each held 50 cycles
      for (int i = 0; i < 4; i++) begin
         sel = 2'(sels[i]);
         tick();
         check("man_cur_ch", 32'(cur_ch), 32'(sels[i]));
         check("man_dout", 32'(dout), 32'(exp_d[i]));
         check("man_strobe", 32'(ch_strobe), (i != 0) ? 1 : 0);
         repeat (49) tick();
         check("man_strobe_hold", 32'(ch_strobe), 0);
      end

      // CH=3: out-of-range request ignored
      sel3 = 2'd1; tick();
      check("ch3_cur_1", 32'(cur3), 1);
      check("ch3_strobe_1", 32'(strb3), 1);
      check("ch3_dout_1", 32'(dout3), 0);
      sel3 = 2'd3; tick();
      check("ch3_cur_oor", 32'(cur3), 1);
      check("ch3_strobe_oor", 32'(strb3), 0);
      check("ch3_dout_oor", 32'(dout3), 0);
      sel3 = 2'd2; tick();
      check("ch3_cur_2", 32'(cur3), 2);
      check("ch3_dout_2", 32'(dout3), 1);

      // SCAN, all channels enabled, from reset
      mode = 1'b1;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int e = 1; e <= 16; e++) begin
         tick();
         check("scan_cur_ch", 32'(cur_ch), 32'((e / 4) % 4));
         check("scan_strobe", 32'(ch_strobe), (e % 4 == 0) ? 1 : 0);
         check("scan_dout", 32'(dout), ((e / 4) % 2 == 0) ? 1 : 0);
      end

      // SCAN with mask 1010, then empty mask
      ch_mask = 4'b1010;
      repeat (4) tick();
      check("mask_cur_1", 32'(cur_ch), 1);
      check("mask_strobe_1", 32'(ch_strobe), 1);
      repeat (4) tick();
      check("mask_cur_3", 32'(cur_ch), 3);
      repeat (4) tick();
      check("mask_cur_1b", 32'(cur_ch), 1);
      ch_mask = 4'b0000;
      repeat (12) tick();
      check("mask0_cur", 32'(cur_ch), 1);
      check("mask0_strobe", 32'(ch_strobe), 0);
      ch_mask = 4'hF;
      repeat (4) tick();
      check("mask_f_cur_2", 32'(cur_ch), 2);
      check("mask_f_strobe", 32'(ch_strobe), 1);

      // en=0 mid-dwell (counter=2) with din toggling
      repeat (2) tick();
      en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         din = 4'($urandom);
         tick();
      end
      check("frz_cur_ch", 32'(cur_ch), 2);
      check("frz_dout", 32'(dout), 1);
      check("frz_strobe", 32'(ch_strobe), 0);
      din = 4'b1010;
      en = 1'b1;
      tick();
      check("resume_cur_ch", 32'(cur_ch), 2);
      check("resume_dout", 32'(dout), 0);
      check("resume_strobe", 32'(ch_strobe), 0);
      tick();
      check("resume_adv_cur", 32'(cur_ch), 3);
      check("resume_adv_dout", 32'(dout), 1);
      check("resume_adv_strobe", 32'(ch_strobe), 1);

      // Async reset at counter=3 on channel 2
      din = 4'b0101;
      repeat (12) tick();
      repeat (3) tick();
      check("pre_rst_cur", 32'(cur_ch), 2);
      check("pre_rst_dout", 32'(dout), 1);
      rst = 1'b1;
      #1;
      check("async_rst_dout", 32'(dout), 0);
      check("async_rst_cur", 32'(cur_ch), 0);
      check("async_rst_strobe", 32'(ch_strobe), 0);
      tick();
      rst = 1'b0;
      for (int e = 1; e <= 3; e++) begin
         tick();
         check("post_rst_dwell", 32'(cur_ch), 0);
      end
      tick();
      check("post_rst_adv_cur", 32'(cur_ch), 1);
      check("post_rst_adv_strobe", 32'(ch_strobe), 1);
      check("post_rst_adv_dout", 32'(dout), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
